gray_alu_pipe: RTL

Parametrised, pipelined successor to the 4-bit Gray-input ALU core. It accepts two Gray-coded operands and a 2-bit opcode under a valid/ready handshake, decodes them to binary, and executes ADD/SUB/AND/OR. Results and flags (Zero, Overflow, Carry) are returned under a second valid/ready handshake. It sits between the operand-source logic and the result consumer, and sustains one operation per cycle.

---
 rtl/gray_alu_pkg.sv | 36 +++
 rtl/gray_alu_exec.sv | 42 ++++
 rtl/gray_alu_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/gray_alu_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray-input ALU pipeline.
package gray_alu_pkg;

    // Conversion helpers work on a fixed-width word; callers zero-extend and truncate.
    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic carry;
    } alu_flags_t;

    // Zero upper bits propagate as zeros, so any WIDTH <= GRAY_MAX_W decodes correctly.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = g;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_alu_exec.sv
// Combinational execute stage: ADD/SUB/AND/OR on binary operands with Zero/Overflow/Carry.
module gray_alu_exec
    import gray_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_b1,
    input  logic [WIDTH-1:0] i_b2,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zero,
    output logic             o_overflow,
    output logic             o_carry
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b2x;
    logic [WIDTH:0]   w_sum;

    assign w_sub = (alu_op_e'(i_op) == OP_SUB);
    assign w_b2x = i_b2 ^ {WIDTH{w_sub}};
    assign w_sum = {1'b0, i_b1} + {1'b0, w_b2x} + {{WIDTH{1'b0}}, w_sub};

    always_comb begin
        o_res      = '0;
        o_overflow = 1'b0;
        o_carry    = 1'b0;
        unique case (alu_op_e'(i_op))
            OP_ADD, OP_SUB: begin
                o_res   = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
                // Same-sign addends producing a different-sign sum == carry-in ^ carry-out.
                o_overflow = (i_b1[WIDTH-1] == w_b2x[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_b1[WIDTH-1]);
            end
            OP_AND: o_res = i_b1 & i_b2;
            OP_OR:  o_res = i_b1 | i_b2;
        endcase
        o_zero = (o_res == '0);
    end

endmodule

// File: rtl/gray_alu_pipe.sv
// Two-stage Gray-input ALU with valid/ready on both sides (WIDTH 2..32).
// Define GRAY_ALU_RESULT_GRAY_EN to return R in Gray code instead of binary.
module gray_alu_pipe
    import gray_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g1,
    input  logic [WIDTH-1:0] g2,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             Zero,
    output logic             Overflow,
    output logic             Carry
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_b1;
    logic [WIDTH-1:0] r_b2;
    logic [1:0]       r_op;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_res;
    alu_flags_t       r_flags;

    logic             w_s2_ready;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_res_enc;
    alu_flags_t       w_flags;

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;

    gray_alu_exec #(
        .WIDTH (WIDTH)
    ) u_exec (
        .i_b1       (r_b1),
        .i_b2       (r_b2),
        .i_op       (r_op),
        .o_res      (w_res),
        .o_zero     (w_flags.zero),
        .o_overflow (w_flags.overflow),
        .o_carry    (w_flags.carry)
    );

`ifdef GRAY_ALU_RESULT_GRAY_EN
    assign w_res_enc = WIDTH'(bin2gray(GRAY_MAX_W'(w_res)));
`else
    assign w_res_enc = w_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_b1       <= '0;
            r_b2       <= '0;
            r_op       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_b1 <= WIDTH'(gray2bin(GRAY_MAX_W'(g1)));
                r_b2 <= WIDTH'(gray2bin(GRAY_MAX_W'(g2)));
                r_op <= op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_flags    <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res   <= w_res_enc;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign R         = r_res;
    assign Zero      = r_flags.zero;
    assign Overflow  = r_flags.overflow;
    assign Carry     = r_flags.carry;

endmodule
